// File: rtl/fifo_rd_drain.sv
// Read-side drain for the async FIFO: pops into a 2-entry skid buffer and streams on valid/ready.
// Optional popped-word counter enabled by defining RD_CNT_EN (adds the rd_count port).
module fifo_rd_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rdclk,
  input  logic                  rd_rst,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  pop,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
`ifdef RD_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  rd_count
`endif
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t                state_q, state_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;

  logic       deq, cap;
  logic [1:0] occ, occ_after;
  logic [2:0] proj;

  assign m_valid = (state_q != S_EMPTY);
  assign m_data  = head_q;

  always_comb begin
    deq        = m_valid && m_ready;
    cap        = inflight_q && !flush;
    occ        = {state_q == S_TWO, state_q == S_ONE};
    occ_after  = occ - {1'b0, deq};
    // Projected occupancy once the in-flight word lands; pop only if it leaves room.
    proj       = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, deq};
    pop        = !empty && !flush && rd_rst && (proj < 3'd2);
    inflight_d = pop;
    head_d     = head_q;
    tail_d     = tail_q;
    state_d    = state_q;

    if (deq && state_q == S_TWO) head_d = tail_q;
    if (cap) begin
      if (occ_after == 2'd0) head_d = data_out;
      else                   tail_d = data_out;
    end

    unique case (state_q)
      S_EMPTY: if (cap) state_d = S_ONE;
      S_ONE: begin
        if (cap && !deq)      state_d = S_TWO;
        else if (!cap && deq) state_d = S_EMPTY;
      end
      S_TWO:   if (deq && !cap) state_d = S_ONE;
      default: state_d = S_EMPTY;
    endcase

    if (flush) state_d = S_EMPTY;
  end

  always_ff @(posedge rdclk or negedge rd_rst) begin
    if (!rd_rst) begin
      state_q    <= S_EMPTY;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // A full buffer never has a word landing without a dequeue to make room.
  always_ff @(posedge rdclk) begin
    if (rd_rst) assert (!(state_q == S_TWO && cap && !deq));
  end

`ifdef RD_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, deq};

  always_ff @(posedge rdclk or negedge rd_rst) begin
    if (!rd_rst) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign rd_count = cnt_q;
`else
  if (CNT_WIDTH < 1) begin : g_cnt_width_unused
  end
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: directed vector table, test-plan sequences and a randomized
// run checked against a queue-based model of the FIFO and of the words still owed downstream.
module tb_fifo_rd_drain;
  localparam int DW = 8;
  localparam int CW = 16;

  logic          rdclk = 1'b0;
  logic          rd_rst = 1'b0;
  logic          empty = 1'b1;
  logic [DW-1:0] data_out = '0;
  logic          pop;
  logic          flush = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
`ifdef RD_CNT_EN
  logic [CW-1:0] rd_count;
`endif

  always #5 rdclk = ~rdclk;

  fifo_rd_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .rdclk(rdclk), .rd_rst(rd_rst), .empty(empty), .data_out(data_out), .pop(pop),
    .flush(flush), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
`ifdef RD_CNT_EN
    , .rd_count(rd_count)
`endif
  );

  typedef struct {
    int            push;
    bit            rdy;
    bit            fl;
    bit            e_pop;
    bit            e_mv;
    bit            chk_md;
    logic [DW-1:0] e_md;
  } vec_t;
  vec_t tbl[15];

  // fq: words sitting in the FIFO; pend: words popped but not yet delivered, in order.
  logic [DW-1:0] fq[$];
  logic [DW-1:0] pend[$];
  logic [DW-1:0] prev_word, held, nw;
  bit            prev_pop, stall_prev, deq;
  int            n_chk, n_pass, cycle, npop, ndeliv, first_deq, last_deq;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cycle);
  endtask

  task automatic push(input logic [DW-1:0] w);
    fq.push_back(w);
  endtask

  task automatic prep(input bit rdy, input bit fl);
    data_out = prev_pop ? prev_word : DW'($urandom);
    empty    = (fq.size() == 0);
    m_ready  = rdy;
    flush    = fl;
    #1;
  endtask

  task automatic fin();
    bit exp_pop;
    deq     = m_valid && m_ready;
    exp_pop = rd_rst && !empty && !flush && ((pend.size() - int'(deq)) < 2);
    chk("pop", 32'(pop), 32'(exp_pop));
    if (pend.size() == 0) chk("idle_valid", 32'(m_valid), 32'd0);
    if (stall_prev) chk("hold", 32'(m_data), 32'(held));
    if (deq && pend.size() > 0) begin
      chk("order", 32'(m_data), 32'(pend[0]));
      void'(pend.pop_front());
      ndeliv++;
      if (first_deq < 0) first_deq = cycle;
      last_deq = cycle;
    end
    if (flush) pend.delete();
    prev_pop = 1'b0;
    if (pop && fq.size() > 0) begin
      prev_word = fq.pop_front();
      pend.push_back(prev_word);
      prev_pop = 1'b1;
      npop++;
    end
    stall_prev = m_valid && !m_ready && !flush && rd_rst;
    held       = m_data;
    cycle++;
    @(negedge rdclk);
  endtask

  task automatic cyc(input bit rdy, input bit fl);
    prep(rdy, fl);
    fin();
  endtask

  initial begin
    int base, pushed, k, p0;
    tbl[0]  = '{0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA0};
    tbl[4]  = '{0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA0};
    tbl[5]  = '{0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA0};
    tbl[6]  = '{0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA1};
    tbl[7]  = '{0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA2};
    tbl[8]  = '{3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[9]  = '{0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[10] = '{0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA3};
    tbl[11] = '{0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[12] = '{0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[13] = '{0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5};
    tbl[14] = '{0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    n_chk = 0; n_pass = 0; cycle = 0; npop = 0; ndeliv = 0;
    first_deq = -1; last_deq = -1;
    prev_pop = 1'b0; stall_prev = 1'b0;

    #3;
    chk("rst_pop", 32'(pop), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
`ifdef RD_CNT_EN
    chk("rst_count", 32'(rd_count), 32'd0);
`endif
    @(negedge rdclk);
    rd_rst = 1'b1;

    // Directed latency / backpressure / flush vectors
    nw = 8'hA0;
    for (int i = 0; i < 15; i++) begin
      repeat (tbl[i].push) begin push(nw); nw++; end
      prep(tbl[i].rdy, tbl[i].fl);
      chk($sformatf("vec%0d_pop", i), 32'(pop), 32'(tbl[i].e_pop));
      chk($sformatf("vec%0d_valid", i), 32'(m_valid), 32'(tbl[i].e_mv));
      if (tbl[i].chk_md) chk($sformatf("vec%0d_data", i), 32'(m_data), 32'(tbl[i].e_md));
      fin();
    end

    // Asynchronous reset with the buffer full
    push(8'h55); push(8'h66);
    repeat (4) cyc(1'b0, 1'b0);
    chk("pre_rst_valid", 32'(m_valid), 32'd1);
    #2 rd_rst = 1'b0;
    #1;
    chk("async_rst_valid", 32'(m_valid), 32'd0);
    chk("async_rst_pop", 32'(pop), 32'd0);
    chk("async_rst_data", 32'(m_data), 32'd0);
    pend.delete(); fq.delete(); prev_pop = 1'b0; stall_prev = 1'b0;
    @(negedge rdclk);
    repeat (2) cyc(1'b1, 1'b0);
    rd_rst = 1'b1;
    cyc(1'b1, 1'b0);
`ifdef RD_CNT_EN
    chk("post_rst_count", 32'(rd_count), 32'd0);
`endif

    // Sustained drain of 0x00..0x0A
    base = ndeliv; first_deq = -1; p0 = cycle;
    for (int i = 0; i <= 10; i++) push(DW'(i));
    repeat (16) cyc(1'b1, 1'b0);
    chk("drain_count", 32'(ndeliv - base), 32'd11);
    chk("drain_first", 32'(first_deq - p0), 32'd2);
    chk("drain_last", 32'(last_deq - p0), 32'd12);
`ifdef RD_CNT_EN
    chk("drain_rd_count", 32'(rd_count), 32'd11);
`endif

    // Backpressure: 10 stalled cycles, then release
    for (int i = 0; i < 16; i++) push(DW'(i));
    p0 = npop;
    repeat (10) cyc(1'b0, 1'b0);
    chk("stall_pops", 32'(npop - p0), 32'd2);
    chk("stall_data", 32'(m_data), 32'h00);
    base = ndeliv;
    repeat (16) cyc(1'b1, 1'b0);
    chk("release_no_gap", 32'(ndeliv - base), 32'd16);
    repeat (4) cyc(1'b1, 1'b0);

    // Underflow: only 5 words available
    base = ndeliv;
    for (int i = 0; i < 5; i++) push(DW'(8'h30 + i));
    repeat (20) cyc(1'b1, 1'b0);
    chk("underflow_count", 32'(ndeliv - base), 32'd5);
    chk("underflow_valid", 32'(m_valid), 32'd0);

    // Random trickle-in with 50% ready
    base = ndeliv; pushed = 0; k = 0;
    while ((ndeliv - base) < 64 && k < 3000) begin
      if (pushed < 64 && $urandom_range(0, 3) != 0) begin
        push(DW'($urandom));
        pushed++;
      end
      cyc(1'($urandom_range(0, 1)), 1'b0);
      k++;
    end
    chk("rand_count", 32'(ndeliv - base), 32'd64);
    chk("rand_leftover", 32'(pend.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
